frv_alu_arb: RTL and testbench

FRV_ALU_ARB -- requirements
Module: frv_alu_arb

---
 rtl/mypackage.sv | 48 ++++
 rtl/frv_alu_arb_if.sv | 28 ++
 rtl/frv_alu.sv | 90 +++++++++
 rtl/frv_alu_arb.sv | 148 ++++++++++++++
 tb/tb_frv_alu_arb.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mypackage.sv
// Shared types for the FRV ALU arbiter: packed ALU op bundle, pack widths, response record.
// Lane width helper maps a pack-width encoding to bits per lane.
package mypackage;

  localparam int XLEN = 32;
  localparam int XL   = XLEN - 1;

  typedef enum logic [2:0] {
    PW_32 = 3'd0,
    PW_16 = 3'd1,
    PW_8  = 3'd2,
    PW_4  = 3'd3,
    PW_2  = 3'd4
  } pw_t;

  typedef struct packed {
    pw_t  pw;
    logic op_add;
    logic op_sub;
    logic op_xor;
    logic op_or;
    logic op_and;
    logic op_shf;
    logic op_rot;
    logic op_shf_left;
    logic op_shf_arith;
    logic op_cmp;
    logic op_unsigned;
  } alu_op_t;

  typedef struct packed {
    logic [XL:0] result;
    logic        lt;
    logic        eq;
    logic [XL:0] add;
  } rsp_t;

  function automatic int lane_width(input pw_t pw);
    case (pw)
      PW_16:   return 16;
      PW_8:    return 8;
      PW_4:    return 4;
      PW_2:    return 2;
      default: return 32;
    endcase
  endfunction

endpackage

// File: rtl/frv_alu_arb_if.sv
// One requester port of the ALU arbiter: request handshake plus registered response handshake.
// master drives requests and consumes responses; slave is the arbiter side.
interface frv_alu_arb_if;
  import mypackage::*;

  logic        valid;
  logic        ready;
  alu_op_t     op;
  logic [XL:0] lhs;
  logic [XL:0] rhs;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [XL:0] result;
  logic        lt;
  logic        eq;
  logic [XL:0] add;

  modport master (
    output valid, op, lhs, rhs, rsp_ready,
    input  ready, rsp_valid, result, lt, eq, add
  );

  modport slave (
    input  valid, op, lhs, rhs, rsp_ready,
    output ready, rsp_valid, result, lt, eq, add
  );

endinterface

// File: rtl/frv_alu.sv
// Combinational packed-SIMD ALU: add/sub, logic, shift/rotate per lane, 32-bit compare.
// Zero latency; ready follows valid unless flushed, so it never stalls.
module frv_alu import mypackage::*; (
  input  logic        valid,
  input  logic        flush,
  output logic        ready,
  input  alu_op_t     op,
  input  logic [XL:0] lhs,
  input  logic [XL:0] rhs,
  output logic [XL:0] result,
  output logic        lt,
  output logic        eq,
  output logic [XL:0] add
);

  int          lw;
  logic        carry;
  logic        bi;
  logic [XL:0] sum;
  logic [XL:0] shf_r;
  int          sh;
  int          base;
  int          pos;
  int          src;
  logic [4:0]  idx;

  assign ready = valid & ~flush;
  assign lw    = lane_width(op.pw);

  // Carry chain is restarted at every lane boundary; sub injects carry-in 1 per lane.
  always_comb begin
    carry = op.op_sub;
    bi    = 1'b0;
    sum   = '0;
    for (int i = 0; i < XLEN; i++) begin
      if ((i & (lw - 1)) == 0) carry = op.op_sub;
      bi     = rhs[i] ^ op.op_sub;
      sum[i] = lhs[i] ^ bi ^ carry;
      carry  = (lhs[i] & bi) | (carry & (lhs[i] ^ bi));
    end
  end

  always_comb begin
    shf_r = '0;
    sh    = {27'b0, rhs[4:0]} & (lw - 1);
    base  = 0;
    pos   = 0;
    src   = 0;
    idx   = '0;
    for (int i = 0; i < XLEN; i++) begin
      base = i & ~(lw - 1);
      pos  = i - base;
      if (op.op_rot) begin
        src      = op.op_shf_left ? ((pos - sh) & (lw - 1)) : ((pos + sh) & (lw - 1));
        idx      = 5'(base + src);
        shf_r[i] = lhs[idx];
      end else if (op.op_shf_left) begin
        src = pos - sh;
        if (src >= 0) begin
          idx      = 5'(base + src);
          shf_r[i] = lhs[idx];
        end
      end else begin
        src = pos + sh;
        if (src < lw) begin
          idx      = 5'(base + src);
          shf_r[i] = lhs[idx];
        end else begin
          idx      = 5'(base + lw - 1);
          shf_r[i] = op.op_shf_arith & lhs[idx];
        end
      end
    end
  end

  assign lt  = op.op_unsigned ? (lhs < rhs) : ($signed(lhs) < $signed(rhs));
  assign eq  = (lhs == rhs);
  assign add = sum;

  always_comb begin
    result = '0;
    if (op.op_cmp)                   result = {{XL{1'b0}}, lt};
    else if (op.op_add || op.op_sub) result = sum;
    else if (op.op_xor)              result = lhs ^ rhs;
    else if (op.op_or)               result = lhs | rhs;
    else if (op.op_and)              result = lhs & rhs;
    else if (op.op_shf || op.op_rot) result = shf_r;
  end

endmodule

// File: rtl/frv_alu_arb.sv
// Two-port arbiter sharing one ALU; responses land in a one-entry buffer per port, latency 1.
// A port stalls while its buffer is full and not draining; port 0 also stalls during flush.
module frv_alu_arb #(
  parameter bit PRIO0      = 1'b1,
  parameter int STARVE_MAX = 4
) (
  input  logic         g_clk,
  input  logic         g_reset,
  input  logic         flush,
  frv_alu_arb_if.slave r0,
  frv_alu_arb_if.slave r1
);
  import mypackage::*;

  localparam int             CW   = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]  SMAX = CW'(STARVE_MAX);

  typedef enum logic {
    LAST_P0 = 1'b0,
    LAST_P1 = 1'b1
  } last_e;

  last_e         last_q, last_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          elig0, elig1;
  logic          gnt0, gnt1;

  alu_op_t       alu_op;
  logic [XL:0]   alu_lhs, alu_rhs;
  logic [XL:0]   alu_result, alu_add;
  logic          alu_lt, alu_eq;
  logic          alu_ready_unused;
  rsp_t          alu_rsp;

  logic          vld0_q, vld1_q;
  rsp_t          rsp0_q, rsp1_q;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      last_q   <= LAST_P1;
      starve_q <= '0;
    end else begin
      last_q   <= last_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    elig0    = r0.valid & (~vld0_q | r0.rsp_ready) & ~flush;
    elig1    = r1.valid & (~vld1_q | r1.rsp_ready);
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    last_d   = last_q;
    starve_d = starve_q;

    if (elig0 && elig1) begin
      if (PRIO0) begin
        if (starve_q == SMAX) gnt1 = 1'b1;
        else                  gnt0 = 1'b1;
      end else if (last_q == LAST_P1) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else begin
      gnt0 = elig0;
      gnt1 = elig1;
    end

    if (gnt0)      last_d = LAST_P0;
    else if (gnt1) last_d = LAST_P1;

    // Counts port-0 wins that happen while port 1 is still asking.
    if (gnt1 || !r1.valid)            starve_d = '0;
    else if (gnt0 && starve_q != SMAX) starve_d = starve_q + 1'b1;
  end

  assign r0.ready = gnt0;
  assign r1.ready = gnt1;

  always_comb begin
    alu_op  = '0;
    alu_lhs = '0;
    alu_rhs = '0;
    if (gnt0) begin
      alu_op  = r0.op;
      alu_lhs = r0.lhs;
      alu_rhs = r0.rhs;
    end else if (gnt1) begin
      alu_op  = r1.op;
      alu_lhs = r1.lhs;
      alu_rhs = r1.rhs;
    end
  end

  frv_alu u_alu (
    .valid  (gnt0 | gnt1),
    .flush  (1'b0),
    .ready  (alu_ready_unused),
    .op     (alu_op),
    .lhs    (alu_lhs),
    .rhs    (alu_rhs),
    .result (alu_result),
    .lt     (alu_lt),
    .eq     (alu_eq),
    .add    (alu_add)
  );

  assign alu_rsp = {alu_result, alu_lt, alu_eq, alu_add};

  // A grant always wins over drain so a back-to-back request keeps rsp_valid high.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      vld0_q <= 1'b0;
      rsp0_q <= '0;
    end else if (gnt0) begin
      vld0_q <= 1'b1;
      rsp0_q <= alu_rsp;
    end else if (flush || r0.rsp_ready) begin
      vld0_q <= 1'b0;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      vld1_q <= 1'b0;
      rsp1_q <= '0;
    end else if (gnt1) begin
      vld1_q <= 1'b1;
      rsp1_q <= alu_rsp;
    end else if (r1.rsp_ready) begin
      vld1_q <= 1'b0;
    end
  end

  assign r0.rsp_valid = vld0_q;
  assign r0.result    = rsp0_q.result;
  assign r0.lt        = rsp0_q.lt;
  assign r0.eq        = rsp0_q.eq;
  assign r0.add       = rsp0_q.add;

  assign r1.rsp_valid = vld1_q;
  assign r1.result    = rsp1_q.result;
  assign r1.lt        = rsp1_q.lt;
  assign r1.eq        = rsp1_q.eq;
  assign r1.add       = rsp1_q.add;

endmodule

// File: tb/tb_frv_alu_arb.sv
// Drives a round-robin and a priority instance with identical stimulus and scores both
// against a cycle-level model of grant rules, response buffers and ALU arithmetic.
module tb_frv_alu_arb;
  import mypackage::*;

  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst;
  logic fl;

  logic        v   [2];
  alu_op_t     op  [2];
  logic [XL:0] lhs [2];
  logic [XL:0] rhs [2];
  logic        rr  [2];

  logic        rdy  [4];
  logic        rsv  [4];
  logic        lto  [4];
  logic        eqo  [4];
  logic [XL:0] reso [4];
  logic [XL:0] addo [4];

  int n_chk  = 0;
  int n_fail = 0;

  bit          mv   [4];
  logic [XL:0] mres [4];
  logic [XL:0] madd [4];
  logic        mlt  [4];
  logic        meq  [4];
  int          last [2];
  int          cnt  [2];

  always #5 clk = ~clk;

  frv_alu_arb_if ifs [4] ();

  for (genvar k = 0; k < 4; k++) begin : g_wire
    assign ifs[k].valid     = v[k % 2];
    assign ifs[k].op        = op[k % 2];
    assign ifs[k].lhs       = lhs[k % 2];
    assign ifs[k].rhs       = rhs[k % 2];
    assign ifs[k].rsp_ready = rr[k % 2];
    assign rdy[k]  = ifs[k].ready;
    assign rsv[k]  = ifs[k].rsp_valid;
    assign reso[k] = ifs[k].result;
    assign lto[k]  = ifs[k].lt;
    assign eqo[k]  = ifs[k].eq;
    assign addo[k] = ifs[k].add;
  end

  frv_alu_arb #(.PRIO0(1'b0), .STARVE_MAX(SMAX)) dut_rr (
    .g_clk(clk), .g_reset(rst), .flush(fl), .r0(ifs[0]), .r1(ifs[1])
  );

  frv_alu_arb #(.PRIO0(1'b1), .STARVE_MAX(SMAX)) dut_pr (
    .g_clk(clk), .g_reset(rst), .flush(fl), .r0(ifs[2]), .r1(ifs[3])
  );

  function automatic alu_op_t mk(input int kind, input pw_t pw, input bit left,
                                 input bit arith, input bit uns);
    alu_op_t o;
    o = '0;
    o.pw = pw;
    case (kind)
      0: o.op_add = 1'b1;
      1: o.op_sub = 1'b1;
      2: o.op_xor = 1'b1;
      3: o.op_or  = 1'b1;
      4: o.op_and = 1'b1;
      5: o.op_shf = 1'b1;
      6: o.op_rot = 1'b1;
      default: o.op_cmp = 1'b1;
    endcase
    o.op_shf_left  = left;
    o.op_shf_arith = arith;
    o.op_unsigned  = uns;
    return o;
  endfunction

  // Lane-by-lane arithmetic on 64-bit integers.
  function automatic void ref_alu(input alu_op_t o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic l, output logic e,
                                  output logic [31:0] ad);
    int lw;
    longint mask, la, lb, sum, x, sh;
    logic [31:0] sr;
    case (o.pw)
      PW_16:   lw = 16;
      PW_8:    lw = 8;
      PW_4:    lw = 4;
      PW_2:    lw = 2;
      default: lw = 32;
    endcase
    mask = (longint'(1) << lw) - 1;
    sh   = longint'(b[4:0]) % lw;
    ad   = '0;
    sr   = '0;
    l    = o.op_unsigned ? (a < b) : ($signed(a) < $signed(b));
    e    = (a == b);
    for (int n = 0; n < 32 / lw; n++) begin
      la  = (longint'(a) >> (n * lw)) & mask;
      lb  = (longint'(b) >> (n * lw)) & mask;
      sum = (o.op_sub ? (la - lb) : (la + lb)) & mask;
      if (o.op_rot)
        x = o.op_shf_left ? ((la << sh) | (la >> (lw - sh))) : ((la >> sh) | (la << (lw - sh)));
      else if (o.op_shf_left)
        x = la << sh;
      else if (o.op_shf_arith && ((la >> (lw - 1)) & 1) != 0)
        x = (la - (longint'(1) << lw)) >>> sh;
      else
        x = la >> sh;
      x  = x & mask;
      ad = ad | 32'(sum << (n * lw));
      sr = sr | 32'(x << (n * lw));
    end
    if (o.op_cmp)                   r = {31'b0, l};
    else if (o.op_add || o.op_sub)  r = ad;
    else if (o.op_xor)              r = a ^ b;
    else if (o.op_or)               r = a | b;
    else if (o.op_and)              r = a & b;
    else if (o.op_shf || o.op_rot)  r = sr;
    else                            r = '0;
  endfunction

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      v[p]   = 1'b0;
      op[p]  = '0;
      lhs[p] = '0;
      rhs[p] = '0;
      rr[p]  = 1'b1;
    end
    fl = 1'b0;
  endtask

  // One clock: compare outputs with the model, advance the model, return at next negedge.
  task automatic cycle();
    int g;
    int k;
    bit e0, e1;
    logic [31:0] r, ad;
    logic l, e;
    #1;
    if (!rst) begin
      for (int q = 0; q < 4; q++) begin
        n_chk++;
        if (rsv[q] !== mv[q]) begin
          n_fail++;
          $display("FAIL rsp_valid k=%0d got %b want %b", q, rsv[q], mv[q]);
        end
        if (mv[q]) begin
          n_chk++;
          if (reso[q] !== mres[q] || addo[q] !== madd[q] || lto[q] !== mlt[q] || eqo[q] !== meq[q]) begin
            n_fail++;
            $display("FAIL rsp_data k=%0d got res=%h add=%h lt=%b eq=%b want res=%h add=%h lt=%b eq=%b",
                     q, reso[q], addo[q], lto[q], eqo[q], mres[q], madd[q], mlt[q], meq[q]);
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      e0 = v[0] && (!mv[2*d] || rr[0]) && !fl;
      e1 = v[1] && (!mv[2*d+1] || rr[1]);
      g = -1;
      if (e0 && e1) g = (d == 0) ? ((last[d] == 0) ? 1 : 0) : ((cnt[d] == SMAX) ? 1 : 0);
      else if (e0)  g = 0;
      else if (e1)  g = 1;
      if (!rst) begin
        n_chk++;
        if (rdy[2*d] !== (g == 0) || rdy[2*d+1] !== (g == 1)) begin
          n_fail++;
          $display("FAIL grant d=%0d got r0=%b r1=%b want port %0d", d, rdy[2*d], rdy[2*d+1], g);
        end
      end
      if (rst) begin
        for (int p = 0; p < 2; p++) begin
          k = 2*d + p;
          mv[k] = 1'b0; mres[k] = '0; madd[k] = '0; mlt[k] = 1'b0; meq[k] = 1'b0;
        end
        last[d] = 1;
        cnt[d]  = 0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          k = 2*d + p;
          if (g == p) begin
            ref_alu(op[p], lhs[p], rhs[p], r, l, e, ad);
            mv[k] = 1'b1; mres[k] = r; madd[k] = ad; mlt[k] = l; meq[k] = e;
          end else if ((p == 0 && fl) || rr[p]) begin
            mv[k] = 1'b0;
          end
        end
        if (g >= 0) last[d] = g;
        if (g == 1 || !v[1])  cnt[d] = 0;
        else if (g == 0)      cnt[d] = (cnt[d] < SMAX) ? cnt[d] + 1 : SMAX;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    repeat (3) cycle();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (rsv[k] !== 1'b0 || reso[k] !== '0 || addo[k] !== '0 || lto[k] !== 1'b0 || eqo[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset k=%0d got vld=%b res=%h add=%h lt=%b eq=%b want all zero",
                 k, rsv[k], reso[k], addo[k], lto[k], eqo[k]);
      end
    end
  endtask

  task automatic test_collision();
    idle();
    v[0] = 1'b1; op[0] = mk(0, PW_32, 0, 0, 0); lhs[0] = 32'd5;  rhs[0] = 32'd3;
    v[1] = 1'b1; op[1] = mk(1, PW_32, 0, 0, 0); lhs[1] = 32'd10; rhs[1] = 32'd4;
    #1;
    n_chk++;
    if (rdy[0] !== 1'b1 || rdy[1] !== 1'b0) begin
      n_fail++; $display("FAIL collision_first got r0=%b r1=%b want 1 0", rdy[0], rdy[1]);
    end
    cycle();
    n_chk++;
    if (rsv[0] !== 1'b1 || reso[0] !== 32'd8) begin
      n_fail++; $display("FAIL collision_r0 got vld=%b res=%0d want 1 8", rsv[0], reso[0]);
    end
    v[0] = 1'b0;
    cycle();
    n_chk++;
    if (rsv[1] !== 1'b1 || reso[1] !== 32'd6) begin
      n_fail++; $display("FAIL collision_r1 got vld=%b res=%0d want 1 6", rsv[1], reso[1]);
    end
    v[0] = 1'b1; op[0] = mk(2, PW_32, 0, 0, 0);
    #1;
    n_chk++;
    if (rdy[0] !== 1'b1 || rdy[1] !== 1'b0) begin
      n_fail++; $display("FAIL collision_next got r0=%b r1=%b want 1 0", rdy[0], rdy[1]);
    end
    cycle();
    idle();
    cycle();
  endtask

  task automatic test_hold();
    idle();
    v[0] = 1'b1; op[0] = mk(2, PW_32, 0, 0, 0); lhs[0] = 32'hF0F0_F0F0; rhs[0] = 32'h0FF0_0FF0;
    rr[0] = 1'b0;
    cycle();
    op[0] = mk(0, PW_32, 0, 0, 0); lhs[0] = 32'd1; rhs[0] = 32'd1;
    v[1] = 1'b1; op[1] = mk(4, PW_32, 0, 0, 0); lhs[1] = 32'hFFFF_0000; rhs[1] = 32'h0F0F_0F0F;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (rdy[0] !== 1'b0 || rdy[1] !== 1'b1 || rsv[0] !== 1'b1 || reso[0] !== 32'hFF00_FF00) begin
        n_fail++;
        $display("FAIL hold i=%0d got r0=%b r1=%b vld=%b res=%h want 0 1 1 ff00ff00",
                 i, rdy[0], rdy[1], rsv[0], reso[0]);
      end
      cycle();
    end
    rr[0] = 1'b1;
    cycle();
    idle();
    cycle();
  endtask

  task automatic test_starve();
    bit exp1;
    idle();
    cycle();
    v[0] = 1'b1; v[1] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      op[0] = mk(0, PW_32, 0, 0, 0); lhs[0] = i; rhs[0] = 32'd1;
      op[1] = mk(3, PW_32, 0, 0, 0); lhs[1] = i; rhs[1] = 32'h100;
      #1;
      exp1 = (i % 5 == 4);
      n_chk++;
      if (rdy[3] !== exp1 || rdy[2] !== !exp1) begin
        n_fail++;
        $display("FAIL starve i=%0d got r0=%b r1=%b want r1=%b", i, rdy[2], rdy[3], exp1);
      end
      cycle();
    end
    idle();
    cycle();
  endtask

  task automatic test_cmp();
    idle();
    v[0] = 1'b1; op[0] = mk(7, PW_32, 0, 0, 0); lhs[0] = 32'hFFFF_FFFF; rhs[0] = 32'd1;
    cycle();
    n_chk++;
    if (reso[0] !== 32'd1 || lto[0] !== 1'b1 || eqo[0] !== 1'b0) begin
      n_fail++; $display("FAIL cmp_signed got res=%h lt=%b eq=%b want 1 1 0", reso[0], lto[0], eqo[0]);
    end
    op[0] = mk(7, PW_32, 0, 0, 1);
    cycle();
    n_chk++;
    if (reso[0] !== 32'd0 || lto[0] !== 1'b0 || eqo[0] !== 1'b0) begin
      n_fail++; $display("FAIL cmp_unsigned got res=%h lt=%b eq=%b want 0 0 0", reso[0], lto[0], eqo[0]);
    end
    idle();
    cycle();
  endtask

  task automatic test_flush();
    idle();
    v[0] = 1'b1; op[0] = mk(3, PW_32, 0, 0, 0); lhs[0] = 32'h1; rhs[0] = 32'h2; rr[0] = 1'b0;
    cycle();
    fl = 1'b1;
    v[1] = 1'b1; op[1] = mk(0, PW_32, 0, 0, 0); lhs[1] = 32'd100; rhs[1] = 32'd23;
    #1;
    n_chk++;
    if (rdy[0] !== 1'b0 || rdy[1] !== 1'b1) begin
      n_fail++; $display("FAIL flush_ready got r0=%b r1=%b want 0 1", rdy[0], rdy[1]);
    end
    cycle();
    fl = 1'b0; v[0] = 1'b0; v[1] = 1'b0;
    n_chk++;
    if (rsv[0] !== 1'b0 || rsv[1] !== 1'b1 || reso[1] !== 32'd123) begin
      n_fail++; $display("FAIL flush_after got v0=%b v1=%b res1=%0d want 0 1 123", rsv[0], rsv[1], reso[1]);
    end
    cycle();
    idle();
    cycle();
  endtask

  task automatic test_reset_inflight();
    idle();
    v[0] = 1'b1; op[0] = mk(0, PW_8, 0, 0, 0); lhs[0] = 32'h80FF_7F01; rhs[0] = 32'h8001_0101;
    v[1] = 1'b1; op[1] = mk(6, PW_16, 1, 0, 0); lhs[1] = 32'h1234_8001; rhs[1] = 32'd4;
    rr[0] = 1'b0; rr[1] = 1'b0;
    cycle();
    cycle();
    n_chk++;
    if (rsv[0] !== 1'b1 || rsv[1] !== 1'b1 || rsv[2] !== 1'b1 || rsv[3] !== 1'b1) begin
      n_fail++; $display("FAIL inflight_full got %b%b%b%b want 1111", rsv[0], rsv[1], rsv[2], rsv[3]);
    end
    rst = 1'b1; rr[0] = 1'b1; rr[1] = 1'b1;
    cycle();
    rst = 1'b0;
    n_chk++;
    if (rsv[0] !== 1'b0 || rsv[1] !== 1'b0 || rsv[2] !== 1'b0 || rsv[3] !== 1'b0) begin
      n_fail++; $display("FAIL inflight_reset got %b%b%b%b want 0000", rsv[0], rsv[1], rsv[2], rsv[3]);
    end
    #1;
    n_chk++;
    if (rdy[0] !== 1'b1 || rdy[1] !== 1'b0 || rdy[2] !== 1'b1 || rdy[3] !== 1'b0) begin
      n_fail++; $display("FAIL inflight_first got %b%b%b%b want 1010", rdy[0], rdy[1], rdy[2], rdy[3]);
    end
    cycle();
    idle();
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      for (int p = 0; p < 2; p++) begin
        v[p]   = ($urandom_range(0, 3) != 0);
        op[p]  = mk($urandom_range(0, 7), pw_t'(3'($urandom_range(0, 4))),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        lhs[p] = $urandom();
        rhs[p] = $urandom();
        rr[p]  = ($urandom_range(0, 9) < 7);
      end
      fl  = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_collision();
    test_hold();
    test_starve();
    test_cmp();
    test_flush();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
